mult_seq_ctrl: RTL and testbench

Sequencing controller for the lookup-table multiplier datapath. It computes an unsigned WIDTH x WIDTH product by time-sharing a single registered 2-bit x 2-bit lookup unit across all digit-pair partial products. It shifts and accumulates the partial products and reports the result through a start/busy/done handshake. It replaces four parallel lookup instances with one, for area-constrained placements.

---
 rtl/mult_seq_ctrl_pkg.sv | 17 +
 rtl/mult2_lut.sv | 24 ++
 rtl/mult_seq_ctrl.sv | 113 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_ctrl_pkg.sv
// Shared constants for the time-shared 2x2 lookup-table multiplier.
package mult_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned LUT_LAT = 1;
  localparam int unsigned DIG     = 2;

  // Nibble k holds (k[3:2] * k[1:0]); entry 15 (3*3=9) is the top nibble.
  localparam logic [63:0] LUT_TABLE = 64'h9630_6420_3210_0000;

endpackage

// File: rtl/mult2_lut.sv
// Registered 2-bit x 2-bit product table with asynchronous clear.
module mult2_lut
  import mult_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  logic [3:0] r_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else begin
      r_p <= LUT_TABLE[{x, y, 2'b00} +: 4];
    end
  end

  assign p = r_p;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencing controller: walks all radix-4 digit pairs through one shared LUT,
// shifting and accumulating the partial products behind a start/busy/done handshake.
module mult_seq_ctrl
  import mult_seq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned D  = WIDTH / DIG;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned SW = $clog2(AW);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  state_e               r_state, w_state_d;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [CW-1:0]        r_i, r_j;
  logic [AW-1:0]        r_acc, w_acc_d, r_out;
  logic [LUT_LAT-1:0]   r_vld;
  logic [LUT_LAT*SW-1:0] r_tag;
  logic                 w_accept, w_issue;
  logic [SW-1:0]        w_tag, w_tag_out;
  logic [DIG-1:0]       w_x, w_y;
  logic [3:0]           w_p;

  assign w_x   = r_a[DIG*r_i +: DIG];
  assign w_y   = r_b[DIG*r_j +: DIG];
  assign w_tag = SW'(DIG * (32'(r_i) + 32'(r_j)));

  mult2_lut u_lut (
    .clk (clk),
    .rst (rst),
    .x   (w_x),
    .y   (w_y),
    .p   (w_p)
  );

  // Shift tag travels alongside the pair so it lines up with the LUT output.
  assign w_tag_out = r_tag[LUT_LAT*SW-1 -: SW];
  assign w_acc_d   = r_acc + (r_vld[LUT_LAT-1] ? (AW'(w_p) << w_tag_out) : '0);

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_issue   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_accept  = 1'b1;
          w_state_d = ST_RUN;
        end else begin
          w_state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_issue = 1'b1;
        if (r_i == LAST && r_j == LAST) w_state_d = ST_DRAIN;
      end
      ST_DRAIN: w_state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_vld   <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_d;
      r_vld   <= LUT_LAT'({r_vld, w_issue});
      r_tag   <= (LUT_LAT*SW)'({r_tag, w_tag});
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_i   <= '0;
        r_j   <= '0;
        r_acc <= '0;
      end else begin
        r_acc <= w_acc_d;
        if (w_issue) begin
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
      end
      // DRAIN folds in the last partial product on the same edge that publishes it.
      if (r_state == ST_DRAIN) r_out <= w_acc_d;
    end
  end

  assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);
  assign out  = r_out;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench: directed table, handshake corner cases, exhaustive and random products.
module tb_mult_seq_ctrl;

  localparam int LAT4 = (4 / 2) * (4 / 2) + 2;
  localparam int LAT8 = (8 / 2) * (8 / 2) + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  out4;
  logic [15:0] out8;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0]  last4 = '0;
  logic [15:0] last8 = '0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .start (start4), .a (a4), .b (b4),
    .busy (busy4), .done (done4), .out (out4)
  );

  mult_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (start8), .a (a8), .b (b8),
    .busy (busy8), .done (done8), .out (out8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Waits for done; busy must stay high and out must hold the previous result until then.
  task automatic wait4(input int n0, output int n, output bit ok);
    n  = n0;
    ok = 1'b1;
    while (!done4 && n < 40) begin
      if (!busy4 || out4 !== last4) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (done4 && busy4) ok = 1'b0;
  endtask

  task automatic wait8(input int n0, output int n, output bit ok);
    n  = n0;
    ok = 1'b1;
    while (!done8 && n < 80) begin
      if (!busy8 || out8 !== last8) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (done8 && busy8) ok = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input string name);
    int n;
    bit ok;
    logic [7:0] exp;
    exp = {4'b0, a} * {4'b0, b};
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom);
    wait4(1, n, ok);
    chk({name, " out"}, 64'(out4), 64'(exp));
    chk({name, " latency"}, 64'(n), 64'(LAT4));
    chk({name, " busy/hold"}, 64'(ok), 64'd1);
    last4 = exp;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input string name);
    int n;
    bit ok;
    logic [15:0] exp;
    exp = {8'b0, a} * {8'b0, b};
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    wait8(1, n, ok);
    chk({name, " out"}, 64'(out8), 64'(exp));
    chk({name, " latency"}, 64'(n), 64'(LAT8));
    chk({name, " busy/hold"}, 64'(ok), 64'd1);
    last8 = exp;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[4];
    int   n;
    bit   ok;
    int   extra;

    tbl[0] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
    tbl[1] = '{a: 4'd0,  b: 4'd13, exp: 8'd0};
    tbl[2] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
    tbl[3] = '{a: 4'd9,  b: 4'd6,  exp: 8'd54};

    rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    chk("reset out", 64'(out4), 64'd0);
    chk("reset busy", 64'(busy4), 64'd0);
    chk("reset done", 64'(done4), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < 4; k++) begin
      op4(tbl[k].a, tbl[k].b, $sformatf("table%0d", k));
      chk($sformatf("table%0d const", k), 64'(out4), 64'(tbl[k].exp));
    end

    // Start held high: three products back to back with no idle cycle.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'd12; b4 = 4'd11;
    wait4(1, n, ok);
    chk("b2b0 out", 64'(out4), 64'd15);
    chk("b2b0 period", 64'(n), 64'(LAT4));
    chk("b2b0 hold", 64'(ok), 64'd1);
    last4 = 8'd15;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7;
    wait4(1, n, ok);
    chk("b2b1 out", 64'(out4), 64'd132);
    chk("b2b1 period", 64'(n), 64'(LAT4));
    chk("b2b1 hold", 64'(ok), 64'd1);
    last4 = 8'd132;
    @(negedge clk);
    start4 = 1'b0;
    wait4(1, n, ok);
    chk("b2b2 out", 64'(out4), 64'd49);
    chk("b2b2 period", 64'(n), 64'(LAT4));
    chk("b2b2 hold", 64'(ok), 64'd1);
    last4 = 8'd49;

    // Start pulsed in RUN with new operands must be ignored.
    @(negedge clk);
    a4 = 4'd6; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    wait4(3, n, ok);
    chk("ignore out", 64'(out4), 64'd42);
    chk("ignore latency", 64'(n), 64'(LAT4));
    last4 = 8'd42;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done4) extra++;
    end
    chk("ignore extra done", 64'(extra), 64'd0);

    // Asynchronous reset in the middle of RUN cycle 2.
    @(negedge clk);
    a4 = 4'd10; b4 = 4'd10; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort out", 64'(out4), 64'd0);
    chk("abort busy", 64'(busy4), 64'd0);
    chk("abort done", 64'(done4), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last4 = '0;
    last8 = '0;
    op4(4'd10, 4'd10, "restart");

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        op4(4'(x), 4'(y), $sformatf("exh %0d*%0d", x, y));
      end
    end

    op8(8'd255, 8'd255, "w8 255*255");
    op8(8'd170, 8'd85, "w8 170*85");
    for (int k = 0; k < 24; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom_range(255, 0));
      op8(ra, rb, $sformatf("w8 rnd %0d*%0d", ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
